// File: rtl/cache_arb_pkg.sv
// Shared types and width helpers for the cache memory-port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQUEST  = 2'b01,
    ST_RESPONSE = 2'b10
  } arb_state_e;

  // Index width for n masters; never below 1 so a 2-master slice stays legal.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int ctr_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin picker: first requesting index found scanning cyclically from ptr_i.
module rr_pick
  import cache_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic [IDX_W:0] idx_s;
  logic           hit_s;

  // Offsets are visited in increasing order; the first hit is kept.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s    = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      idx_s    = (idx_s >= (IDX_W + 1)'(N)) ? idx_s - (IDX_W + 1)'(N) : idx_s;
      hit_s    = !any_o && req_i[idx_s[IDX_W-1:0]];
      winner_o = hit_s ? idx_s[IDX_W-1:0] : winner_o;
      any_o    = any_o | hit_s;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between N cache masters with
// round-robin arbitration, per-master line lock and a response watchdog.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      m_req_i,
  input  logic [N_MASTERS*32-1:0]   m_addr_i,
  input  logic [N_MASTERS*32-1:0]   m_wdata_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS*4-1:0]    m_be_i,
  input  logic [N_MASTERS-1:0]      m_lock_i,
  output logic [N_MASTERS-1:0]      m_gnt_o,
  output logic [N_MASTERS-1:0]      m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic [N_MASTERS-1:0]      m_error_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic                      mem_we_o,
  output logic                      mem_req_o,
  output logic [3:0]                mem_be_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic                      mem_error_i
);

  localparam int                 IDX_W    = idx_width(N_MASTERS);
  localparam int                 WD_W     = ctr_width(TIMEOUT);
  localparam bit                 WD_EN    = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0]    WD_MAX   = {WD_W{1'b1}};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_MASTERS - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 lock_hold_q, lock_hold_d;
  logic [WD_W-1:0]      wd_ctr_q, wd_ctr_d;

  logic [IDX_W-1:0]     pick_s;
  logic                 any_s;
  logic [IDX_W-1:0]     next_ptr_s;
  logic                 timeout_s;
  logic [N_MASTERS-1:0] owner_oh_s;

  logic [31:0]          addr_s  [N_MASTERS];
  logic [31:0]          wdata_s [N_MASTERS];
  logic [3:0]           be_s    [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_slice
    assign addr_s[k]  = m_addr_i[32*k +: 32];
    assign wdata_s[k] = m_wdata_i[32*k +: 32];
    assign be_s[k]    = m_be_i[4*k +: 4];
  end

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i    (m_req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_s),
    .any_o    (any_s)
  );

  // Explicit wrap keeps the pointer legal for non-power-of-2 master counts.
  assign next_ptr_s = (owner_q == LAST_IDX) ? {IDX_W{1'b0}} : owner_q + IDX_W'(1);
  assign timeout_s  = WD_EN && (wd_ctr_q == WD_LAST);
  assign owner_oh_s = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_hold_q <= 1'b0;
      wd_ctr_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_hold_q <= lock_hold_d;
      wd_ctr_q    <= wd_ctr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_hold_d = lock_hold_q;
    wd_ctr_d    = wd_ctr_q;
    m_gnt_o     = '0;
    m_rvalid_o  = '0;
    m_error_o   = '0;
    m_rdata_o   = 32'h0000_0000;
    mem_req_o   = 1'b0;
    mem_addr_o  = 32'h0000_0000;
    mem_wdata_o = 32'h0000_0000;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (lock_hold_q && m_req_i[owner_q]) begin
          state_d = ST_REQUEST;
        end else begin
          // A lapsed lock falls straight through to normal arbitration.
          lock_hold_d = 1'b0;
          if (any_s) begin
            owner_d = pick_s;
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_REQUEST: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = addr_s[owner_q];
        mem_wdata_o = wdata_s[owner_q];
        mem_we_o    = m_we_i[owner_q];
        mem_be_o    = be_s[owner_q];
        if (mem_gnt_i) begin
          m_gnt_o  = owner_oh_s;
          wd_ctr_d = '0;
          state_d  = ST_RESPONSE;
        end else begin
          state_d  = ST_REQUEST;
        end
      end

      ST_RESPONSE: begin
        wd_ctr_d  = (wd_ctr_q == WD_MAX) ? wd_ctr_q : wd_ctr_q + WD_W'(1);
        m_rdata_o = mem_rdata_i;
        if (mem_rvalid_i) begin
          m_rvalid_o  = owner_oh_s;
          m_error_o   = mem_error_i ? owner_oh_s : '0;
          lock_hold_d = m_lock_i[owner_q];
          rr_ptr_d    = m_lock_i[owner_q] ? rr_ptr_q : next_ptr_s;
          state_d     = ST_IDLE;
        end else if (timeout_s) begin
          m_rvalid_o  = owner_oh_s;
          m_error_o   = owner_oh_s;
          m_rdata_o   = 32'h0000_0000;
          lock_hold_d = 1'b0;
          rr_ptr_d    = next_ptr_s;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESPONSE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one PULPino-style memory port (req/gnt/rvalid) between N cache memory-side masters, e.g. instruction cache and data cache.
- Round-robin arbitration; at most one outstanding transaction.
- Per-master lock keeps ownership across a multi-word line refill.
- Response watchdog converts a missing mem_rvalid_i into an error response.
- Sits between the caches' mem_* ports and the system bus.

Parameters:
- N_MASTERS, 2, number of requesters (≥2).
- TIMEOUT, 255, max Response cycles before error (0 = watchdog disabled).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_req_i  in  N_MASTERS  per-master request, held until granted
m_addr_i  in  N_MASTERS*32  per-master address, slice k = [32k+:32]
m_wdata_i  in  N_MASTERS*32  per-master write data
m_we_i  in  N_MASTERS  per-master write enable
m_be_i  in  N_MASTERS*4  per-master byte enables
m_lock_i  in  N_MASTERS  keep ownership after this transaction
m_gnt_o  out  N_MASTERS  per-master grant
m_rvalid_o  out  N_MASTERS  per-master response valid
m_rdata_o  out  32  response data, shared by all masters
m_error_o  out  N_MASTERS  per-master response error
mem_addr_o, mem_wdata_o  out  32 each  to memory
mem_we_o, mem_req_o  out  1 each  to memory
mem_be_o  out  4  to memory
mem_rdata_i  in  32  from memory
mem_gnt_i, mem_rvalid_i, mem_error_i  in  1 each  from memory

Behaviour:
- Reset (sync, registered): state=Idle, owner=0, rr_ptr=0, lock_hold=0, wd_ctr=0. All outputs are combinational from state, so every output is 0 during and after reset. Reset mid-transaction abandons it silently; no response is issued.
- States: Idle, Request, Response.
- Idle:
  - Outputs all 0.
  - If any m_req_i is set, register the winner into owner and go to Request.
  - Winner: if lock_hold and m_req_i[owner], the winner is owner. Otherwise the first set bit scanning cyclically from rr_ptr.
  - If lock_hold and !m_req_i[owner], clear lock_hold and arbitrate normally in the same cycle.
  - A req first seen in cycle N gives mem_req_o=1 in cycle N+1.
- Request:
  - mem_req_o=1. mem_addr/wdata/we/be are driven combinationally from owner's live slice; the master holds them stable until gnt.
  - m_gnt_o[owner]=mem_gnt_i; all other gnt bits are 0.
  - On mem_gnt_i go to Response and clear wd_ctr.
  - There is no timeout in Request.
  - mem_rvalid_i in Request or Idle has no pending owner and is discarded.
- Response:
  - mem_req_o=0, m_rdata_o=mem_rdata_i, m_rvalid_o[owner]=mem_rvalid_i, m_error_o[owner]=mem_rvalid_i&mem_error_i.
  - wd_ctr increments each cycle. Width is clog2(TIMEOUT+1); it saturates and never wraps.
  - Normal completion on mem_rvalid_i:
    - rr_ptr=(owner+1) mod N_MASTERS, computed as an explicit compare-and-wrap (N need not be a power of 2).
    - lock_hold=m_lock_i[owner]; if the lock is set, rr_ptr is NOT advanced.
    - Go to Idle.
  - Timeout (TIMEOUT≠0, wd_ctr==TIMEOUT-1 and no mem_rvalid_i):
    - For one cycle: m_rvalid_o[owner]=1, m_error_o[owner]=1, m_rdata_o=0.
    - lock_hold=0, rr_ptr advances as for normal completion, go to Idle.
  - mem_rvalid_i and timeout in the same cycle: the real response wins.
- m_rdata_o is 0 outside Response.
- Throughput: at most one transaction per 3 cycles (Idle, Request ≥1, Response ≥1).
- Non-owner m_req_i bits are ignored while busy. They remain pending, so no requests are lost.

Decomposition:
- Package cache_arb_pkg: state enum (Idle=2'b00, Request=2'b01, Response=2'b10); helper constant for clog2(N_MASTERS) with minimum 1.
- Sub-module rr_pick: combinational. Inputs: req vector, rr_ptr. Outputs: winner index and any_req.
- All registers live in cache_mem_arbiter: state, owner, rr_ptr, lock_hold, wd_ctr.

Test Plan:
1. Single master: m_req_i=01 at cycle 0, mem_gnt_i at cycle 2, mem_rvalid_i with rdata=0xDEADBEEF at cycle 4 → mem_req_o=1 in cycles 1–2 with master-0 address; m_gnt_o=01 in cycle 2; m_rvalid_o=01 and m_rdata_o=0xDEADBEEF in cycle 4; rr_ptr=1.
2. Contention: m_req_i=11 held continuously, memory grants and responds immediately → grants alternate 01, 10, 01, 10; no master is granted twice in a row.
3. Lock: master 0 issues 4 reads with m_lock_i[0]=1 on the first three while master 1 also requests → four consecutive master-0 grants, then master 1 is granted next.
4. Timeout: TIMEOUT=8, grant given, no rvalid → m_rvalid_o[owner]=1, m_error_o[owner]=1, m_rdata_o=0 exactly 8 cycles after gnt. A late mem_rvalid_i while Idle produces no m_rvalid_o.
5. Error passthrough: mem_rvalid_i=1 with mem_error_i=1 → m_error_o[owner]=1 for that cycle only; lock_hold and rr_ptr update normally.
6. Reset in Response: assert reset → next cycle all outputs 0 and state Idle. A pending m_req_i=10 afterwards is granted first, because rr_ptr=0 and only master 1 requests.
